// File: rtl/main_memory_model_if.sv
`default_nettype none
// ============================================================================
//  Module   : main_memory_model_if
//  Purpose  : Cache <-> main memory bus: address/data/write request and the
//             registered read data with its status strobes.
//  Revision : 1.0  initial release
// ============================================================================
interface main_memory_model_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_write_en;
    logic [31:0] mem_data_out;
    logic        mem_rd_valid;
    logic        mem_wr_done;
    logic        mem_busy;

    modport master (
        output mem_addr, mem_data_in, mem_write_en,
        input  mem_data_out, mem_rd_valid, mem_wr_done, mem_busy
    );

    modport slave (
        input  mem_addr, mem_data_in, mem_write_en,
        output mem_data_out, mem_rd_valid, mem_wr_done, mem_busy
    );
endinterface
`default_nettype wire

// File: rtl/main_memory_model.sv
`default_nettype none
// ============================================================================
//  Module   : main_memory_model
//  Purpose  : Word-organised main memory with a fixed-latency read pipe and a
//             hold-to-commit write FSM that commits once per request.
//  Revision : 1.0  initial release
// ============================================================================
module main_memory_model #(
    parameter int DEPTH     = 65536,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 3,
    parameter     INIT_FILE = ""
) (
    input  wire logic             clk,
    input  wire logic             rst,
    main_memory_model_if.slave    bus
);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(WRITE_LAT + 2);
    localparam logic [c_CNT_W-1:0] c_WL  = c_CNT_W'(WRITE_LAT);
    localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITING = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    logic [31:0]        r_mem [DEPTH];
    logic [c_IDX_W-1:0] w_idx;
    logic               w_unused_addr_bits;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [c_IDX_W-1:0] r_wa, w_wa_nxt, w_cm_addr;
    logic [31:0]        r_wd, w_wd_nxt, w_cm_data;
    logic               w_commit;
    logic               w_new_req;
    logic               r_wr_done;

    logic               w_rd_vld_in;
    logic [31:0]        w_rd_dat_in;
    logic               w_last_vld;
    logic [31:0]        w_last_dat;
    logic [31:0]        r_data_out;
    logic               r_rd_valid;

    // Upper and byte-offset address bits alias onto the same word.
    assign w_idx              = bus.mem_addr[c_IDX_W+1:2];
    assign w_unused_addr_bits = ^{bus.mem_addr[31:c_IDX_W+2], bus.mem_addr[1:0]};

    if (1) begin : g_init
        initial begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] = '0;
            end
        end
    end

    // Reads see the array as of the sampling edge, before any same-edge commit.
    assign w_rd_vld_in = ~bus.mem_write_en;
    assign w_rd_dat_in = r_mem[w_idx];

    if (READ_LAT == 1) begin : g_direct
        assign w_last_vld = w_rd_vld_in;
        assign w_last_dat = w_rd_dat_in;
    end else begin : g_pipe
        logic [READ_LAT-2:0] r_vld;
        logic [31:0]         r_dat [READ_LAT-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= w_rd_vld_in;
                r_dat[0] <= w_rd_dat_in;
                for (int i = 1; i < READ_LAT - 1; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end

        assign w_last_vld = r_vld[READ_LAT-2];
        assign w_last_dat = r_dat[READ_LAT-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_last_vld;
            if (w_last_vld) begin
                r_data_out <= w_last_dat;
            end
        end
    end

    assign w_cnt_inc = r_cnt + c_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wa_nxt    = r_wa;
        w_wd_nxt    = r_wd;
        w_commit    = 1'b0;
        w_cm_addr   = r_wa;
        w_cm_data   = r_wd;
        w_new_req   = (w_idx != r_wa) || (bus.mem_data_in != r_wd);
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_write_en) begin
                    w_wa_nxt  = w_idx;
                    w_wd_nxt  = bus.mem_data_in;
                    w_cnt_nxt = c_ONE;
                    if (WRITE_LAT == 1) begin
                        w_commit    = 1'b1;
                        w_cm_addr   = w_idx;
                        w_cm_data   = bus.mem_data_in;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_WRITING;
                    end
                end
            end
            ST_WRITING: begin
                if (!bus.mem_write_en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_WL) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.mem_write_en) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_new_req) begin
                    // Passing through WRITING keeps commits at least one edge apart.
                    w_wa_nxt    = w_idx;
                    w_wd_nxt    = bus.mem_data_in;
                    w_cnt_nxt   = c_ONE;
                    w_state_nxt = ST_WRITING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wa      <= '0;
            r_wd      <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wa      <= w_wa_nxt;
            r_wd      <= w_wd_nxt;
            r_wr_done <= w_commit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            r_mem[w_cm_addr] <= w_cm_data;
        end
    end

    assign bus.mem_data_out = r_data_out;
    assign bus.mem_rd_valid = r_rd_valid;
    assign bus.mem_wr_done  = r_wr_done;
    assign bus.mem_busy     = (r_state == ST_WRITING);
endmodule
`default_nettype wire

// File: tb/tb_main_memory_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_main_memory_model
//  Purpose  : Directed, table-driven bench for main_memory_model (default
//             DEPTH/READ_LAT/WRITE_LAT).
//  Revision : 1.0  initial release
// ============================================================================
module tb_main_memory_model;
    localparam int c_DEPTH = 65536;
    localparam int c_NV    = 19;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        exp_vld;
        logic [31:0] exp_data;
        logic        exp_done;
        logic        exp_busy;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n_done;
    logic [2:0] r_done_bits;
    vec_t tv [c_NV];

    main_memory_model_if u_if ();

    main_memory_model u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        u_if.mem_addr     = addr;
        u_if.mem_data_in  = data;
        u_if.mem_write_en = 1'b1;
        repeat (3) step();
        check($sformatf("write %h wr_done", addr), {31'd0, u_if.mem_wr_done}, 32'd1);
        u_if.mem_write_en = 1'b0;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst               = 1'b1;
        u_if.mem_addr     = 32'h0;
        u_if.mem_data_in  = 32'h0;
        u_if.mem_write_en = 1'b0;

        // {rst, we, addr, din, exp_vld, exp_data, exp_done, exp_busy}
        // reset, then hold 0x100 for the first read
        tv[0]  = '{1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0};
        // three-cycle write of 0xDEADBEEF to 0x100
        tv[5]  = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b0, 32'h100, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        // aborted two-cycle write to 0x200
        tv[12] = '{1'b0, 1'b1, 32'h200, 32'h1234,     1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b1, 32'h200, 32'h1234,     1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b0, 32'h200, 32'h1234,     1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        tv[15] = '{1'b0, 1'b0, 32'h200, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        tv[16] = '{1'b0, 1'b0, 32'h200, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        tv[17] = '{1'b0, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0};
        tv[18] = '{1'b0, 1'b0, 32'h200, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0};

        for (int i = 0; i < c_NV; i++) begin
            rst               = tv[i].rst;
            u_if.mem_write_en = tv[i].we;
            u_if.mem_addr     = tv[i].addr;
            u_if.mem_data_in  = tv[i].din;
            step();
            check($sformatf("v%0d rd_valid", i), {31'd0, u_if.mem_rd_valid}, {31'd0, tv[i].exp_vld});
            check($sformatf("v%0d data_out", i), u_if.mem_data_out, tv[i].exp_data);
            check($sformatf("v%0d wr_done", i),  {31'd0, u_if.mem_wr_done},  {31'd0, tv[i].exp_done});
            check($sformatf("v%0d busy", i),     {31'd0, u_if.mem_busy},     {31'd0, tv[i].exp_busy});
        end

        // Long constant hold commits once; an address change re-arms the FSM.
        u_if.mem_addr     = 32'h400;
        u_if.mem_data_in  = 32'hCAFE0001;
        u_if.mem_write_en = 1'b1;
        n_done = 0;
        repeat (10) begin
            step();
            n_done += int'(u_if.mem_wr_done);
        end
        check("hold single commit count", n_done, 32'd1);
        u_if.mem_addr = 32'h300;
        for (int k = 0; k < 3; k++) begin
            step();
            r_done_bits[k] = u_if.mem_wr_done;
        end
        check("re-arm commit timing", {29'd0, r_done_bits}, 32'b100);
        u_if.mem_write_en = 1'b0;
        repeat (4) step();
        check("read 0x300 valid", {31'd0, u_if.mem_rd_valid}, 32'd1);
        check("read 0x300 data",  u_if.mem_data_out, 32'hCAFE0001);

        // Reset on the second write cycle: nothing committed, outputs cleared.
        step();
        u_if.mem_addr     = 32'h500;
        u_if.mem_data_in  = 32'h55;
        u_if.mem_write_en = 1'b1;
        step();
        check("pre-reset busy", {31'd0, u_if.mem_busy}, 32'd1);
        rst = 1'b1;
        step();
        check("mid-write rst data_out", u_if.mem_data_out, 32'h0);
        check("mid-write rst rd_valid", {31'd0, u_if.mem_rd_valid}, 32'd0);
        check("mid-write rst wr_done",  {31'd0, u_if.mem_wr_done},  32'd0);
        check("mid-write rst busy",     {31'd0, u_if.mem_busy},     32'd0);
        rst = 1'b0;
        u_if.mem_write_en = 1'b0;
        repeat (3) step();
        check("post-rst 3rd edge rd_valid", {31'd0, u_if.mem_rd_valid}, 32'd0);
        step();
        check("post-rst 4th edge rd_valid", {31'd0, u_if.mem_rd_valid}, 32'd1);
        check("aborted 0x500 stays zero",   u_if.mem_data_out, 32'h0);

        // Back-to-back reads, last one aliasing onto word 0.
        do_write(32'h0, 32'h11111111);
        do_write(32'h4, 32'h22222222);
        do_write(32'h8, 32'h33333333);
        u_if.mem_addr = 32'h0;          step();
        u_if.mem_addr = 32'h4;          step();
        u_if.mem_addr = 32'h8;          step();
        u_if.mem_addr = 4 * c_DEPTH;    step();
        check("b2b[0] valid", {31'd0, u_if.mem_rd_valid}, 32'd1);
        check("b2b[0] data",  u_if.mem_data_out, 32'h11111111);
        u_if.mem_addr = 32'hC;          step();
        check("b2b[1] valid", {31'd0, u_if.mem_rd_valid}, 32'd1);
        check("b2b[1] data",  u_if.mem_data_out, 32'h22222222);
        step();
        check("b2b[2] valid", {31'd0, u_if.mem_rd_valid}, 32'd1);
        check("b2b[2] data",  u_if.mem_data_out, 32'h33333333);
        step();
        check("b2b[3] alias valid", {31'd0, u_if.mem_rd_valid}, 32'd1);
        check("b2b[3] alias data",  u_if.mem_data_out, 32'h11111111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
